// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALU operation classes and the ID control bundle shared by the pipeline.
package mips_pkg;
  localparam int REG_W = 5;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_e;
  typedef struct packed {
    aluop_e aluop;
    logic   regdst;
    logic   alusrc;
    logic   regwrite;
    logic   memtoreg;
    logic   memwrite;
    logic   memread;
    logic   branch;
    logic   jump;
  } ctrl_t;
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: IF/ID, write-back and hazard inputs plus the decoded bundle toward idex.
interface id_stage_if #(parameter int XLEN = 32);
  import mips_pkg::*;
  logic [31:0]      ifid_instr;
  logic [XLEN-1:0]  ifid_next_instr;
  logic             wb_regwrite;
  logic [REG_W-1:0] wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rt;
  logic             flush;
  logic [XLEN-1:0]  data1, data2, imm, jump_addr, next_instr;
  logic [REG_W-1:0] rs, rt, rd;
  logic [1:0]       aluOP;
  logic             regdst, alusrc, regwrite, memtoreg, memwrite, memread, branch, jump;
  logic             stall;
  modport master (
    output ifid_instr, ifid_next_instr, wb_regwrite, wb_rd, wb_data, idex_memread, idex_rt, flush,
    input  data1, data2, imm, jump_addr, next_instr, rs, rt, rd, aluOP,
           regdst, alusrc, regwrite, memtoreg, memwrite, memread, branch, jump, stall
  );
  modport slave (
    input  ifid_instr, ifid_next_instr, wb_regwrite, wb_rd, wb_data, idex_memread, idex_rt, flush,
    output data1, data2, imm, jump_addr, next_instr, rs, rt, rd, aluOP,
           regdst, alusrc, regwrite, memtoreg, memwrite, memread, branch, jump, stall
  );
endinterface

// File: rtl/id_stage_regfile.sv
// regfile: 2R1W register file, r0 hardwired to zero, write-through bypass, async clear.
module regfile
  import mips_pkg::*;
#(
  parameter int RF_DEPTH = 32,
  parameter int XLEN     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ra1_i,
  input  logic [REG_W-1:0] ra2_i,
  input  logic             we_i,
  input  logic [REG_W-1:0] wa_i,
  input  logic [XLEN-1:0]  wd_i,
  output logic [XLEN-1:0]  rd1_o,
  output logic [XLEN-1:0]  rd2_o
);
  logic [XLEN-1:0] mem_q [RF_DEPTH];
  logic            wr_en;
  assign wr_en = we_i && (wa_i != '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wa_i] <= wd_i;
    end
  end
  // Bypass stays live during reset so write-back data is still forwarded.
  assign rd1_o = (wr_en && wa_i == ra1_i) ? wd_i : (ra1_i == '0 ? '0 : mem_q[ra1_i]);
  assign rd2_o = (wr_en && wa_i == ra2_i) ? wd_i : (ra2_i == '0 ? '0 : mem_q[ra2_i]);
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode stage -- register reads, control decode, immediates and load-use stall.
module id_stage
  import mips_pkg::*;
#(
  parameter int RF_DEPTH = 32,
  parameter int XLEN     = 32
) (
  input logic      clk,
  input logic      rst_n,
  id_stage_if.slave bus
);
  logic [5:0] op;
  logic       uses_rt;
  ctrl_t      dec, ctrl;
  assign op         = bus.ifid_instr[31:26];
  assign bus.rs     = bus.ifid_instr[25:21];
  assign bus.rt     = bus.ifid_instr[20:16];
  assign bus.rd     = bus.ifid_instr[15:11];
  assign bus.imm    = {{(XLEN-16){bus.ifid_instr[15]}}, bus.ifid_instr[15:0]};
  assign bus.jump_addr  = {bus.ifid_next_instr[XLEN-1 -: 4], bus.ifid_instr[25:0], 2'b00};
  assign bus.next_instr = bus.ifid_next_instr;
  regfile #(.RF_DEPTH(RF_DEPTH), .XLEN(XLEN)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1_i (bus.rs),
    .ra2_i (bus.rt),
    .we_i  (bus.wb_regwrite),
    .wa_i  (bus.wb_rd),
    .wd_i  (bus.wb_data),
    .rd1_o (bus.data1),
    .rd2_o (bus.data2)
  );
  always_comb begin
    dec = '0;
    case (op)
      OP_RTYPE: begin dec.aluop = ALU_FUNCT; dec.regdst = 1'b1; dec.regwrite = 1'b1; end
      OP_LW:    begin dec.alusrc = 1'b1; dec.memtoreg = 1'b1; dec.regwrite = 1'b1; dec.memread = 1'b1; end
      OP_SW:    begin dec.alusrc = 1'b1; dec.memwrite = 1'b1; end
      OP_BEQ:   begin dec.aluop = ALU_SUB; dec.branch = 1'b1; end
      OP_ADDI:  begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
      OP_J:     dec.jump = 1'b1;
      default:  dec = '0;
    endcase
  end
  assign uses_rt   = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  assign bus.stall = bus.idex_memread && (bus.idex_rt != '0) &&
                     ((bus.idex_rt == bus.rs) || (uses_rt && bus.idex_rt == bus.rt));
  // Stall and flush both turn the bundle into a bubble; specifiers and data pass unchanged.
  assign ctrl         = (bus.stall || bus.flush) ? '0 : dec;
  assign bus.aluOP    = ctrl.aluop;
  assign bus.regdst   = ctrl.regdst;
  assign bus.alusrc   = ctrl.alusrc;
  assign bus.regwrite = ctrl.regwrite;
  assign bus.memtoreg = ctrl.memtoreg;
  assign bus.memwrite = ctrl.memwrite;
  assign bus.memread  = ctrl.memread;
  assign bus.branch   = ctrl.branch;
  assign bus.jump     = ctrl.jump;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors with hand-computed expectations for id_stage.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  id_stage_if #(.XLEN(32)) bus ();
  id_stage #(.RF_DEPTH(32), .XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ctl();
    return {22'd0, bus.aluOP, bus.regdst, bus.alusrc, bus.regwrite, bus.memtoreg,
            bus.memwrite, bus.memread, bus.branch, bus.jump};
  endfunction
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    bus.wb_regwrite = en;
    bus.wb_rd = r;
    bus.wb_data = d;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.ifid_instr = 32'h00A00000;
    bus.ifid_next_instr = 32'h0;
    wb(1'b0, 5'd0, 32'h0);
    bus.idex_memread = 1'b0;
    bus.idex_rt = 5'd0;
    bus.flush = 1'b0;
    #1;
    check("reset_data1", bus.data1, 32'h0);
    check("reset_stall", {31'd0, bus.stall}, 32'h0);
    cycle();
    rst_n = 1'b1;
    #1;
    check("r5_initial", bus.data1, 32'h0);
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("r5_bypass", bus.data1, 32'hDEADBEEF);
    cycle();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    check("r5_stored", bus.data1, 32'hDEADBEEF);
    bus.ifid_instr = 32'h00000000;
    wb(1'b1, 5'd0, 32'h1234);
    #1;
    check("r0_write_read", bus.data1, 32'h0);
    cycle();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    check("r0_later", bus.data1, 32'h0);
    bus.ifid_instr = 32'h00E71820;
    wb(1'b1, 5'd7, 32'hA5A5A5A5);
    #1;
    check("add_bypass_d1", bus.data1, 32'hA5A5A5A5);
    check("add_bypass_d2", bus.data2, 32'hA5A5A5A5);
    check("rtype_ctl", ctl(), 32'b10_1010_0000);
    check("add_rd", {27'd0, bus.rd}, 32'd3);
    cycle();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    check("r7_stored", bus.data2, 32'hA5A5A5A5);
    bus.idex_memread = 1'b1;
    bus.idex_rt = 5'd8;
    bus.ifid_instr = 32'h01020820;
    #1;
    check("lu_rs_stall", {31'd0, bus.stall}, 32'd1);
    check("lu_rs_bubble", ctl(), 32'h0);
    check("lu_rs_spec", {27'd0, bus.rs}, 32'd8);
    bus.ifid_instr = 32'h20490005;
    #1;
    check("addi_stall", {31'd0, bus.stall}, 32'd0);
    check("addi_ctl", ctl(), 32'b00_0110_0000);
    check("addi_imm", bus.imm, 32'h5);
    bus.ifid_instr = 32'h8C44FFFC;
    #1;
    check("lw_stall", {31'd0, bus.stall}, 32'd0);
    check("lw_imm", bus.imm, 32'hFFFFFFFC);
    check("lw_ctl", ctl(), 32'b00_0111_0100);
    bus.ifid_instr = 32'hAC480000;
    #1;
    check("sw_rt_stall", {31'd0, bus.stall}, 32'd1);
    bus.ifid_instr = 32'h20480001;
    #1;
    check("addi_rt_nostall", {31'd0, bus.stall}, 32'd0);
    bus.idex_rt = 5'd0;
    bus.ifid_instr = 32'h00000020;
    #1;
    check("rt0_nostall", {31'd0, bus.stall}, 32'd0);
    bus.idex_memread = 1'b0;
    bus.ifid_instr = 32'hAC480000;
    #1;
    check("sw_ctl", ctl(), 32'b00_0100_1000);
    bus.ifid_instr = 32'h10000000;
    #1;
    check("beq_ctl", ctl(), 32'b01_0000_0010);
    bus.ifid_instr = 32'hFC000000;
    #1;
    check("unknown_ctl", ctl(), 32'h0);
    bus.ifid_instr = 32'h08000100;
    bus.ifid_next_instr = 32'h40000004;
    #1;
    check("j_addr", bus.jump_addr, 32'h40000400);
    check("j_ctl", ctl(), 32'b00_0000_0001);
    check("next_instr", bus.next_instr, 32'h40000004);
    bus.flush = 1'b1;
    #1;
    check("j_flush", {31'd0, bus.jump}, 32'd0);
    bus.idex_memread = 1'b1;
    bus.idex_rt = 5'd8;
    bus.ifid_instr = 32'h01020820;
    #1;
    check("stall_with_flush", {31'd0, bus.stall}, 32'd1);
    bus.flush = 1'b0;
    bus.idex_memread = 1'b0;
    bus.ifid_instr = 32'h01400000;
    wb(1'b1, 5'd10, 32'h00000055);
    cycle();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    check("r10_stored", bus.data1, 32'h55);
    #1;
    rst_n = 1'b0;
    #1;
    check("r10_async_clear", bus.data1, 32'h0);
    wb(1'b1, 5'd10, 32'h00000077);
    #1;
    check("reset_bypass", bus.data1, 32'h77);
    cycle();
    wb(1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    #1;
    check("reset_write_blocked", bus.data1, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
